// File: rtl/led_panel_pkg.sv
// Shared types and constants for the LED panel scan controller.
package led_panel_pkg;

    // Device index width; covers chains of up to 32 drivers.
    localparam int DEV_IDX_W = 5;

    // Serial word length of one LED driver device.
    localparam int DEFAULT_BITS_PER_DEVICE = 16;

    // Frame refresh sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_SHIFT     = 3'd2,
        ST_LATCH     = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/led_dev_counter.sv
// Device index counter: clock-enabled, wraps to 0 after NUMBER_OF_DEVICES-1.
module led_dev_counter
    import led_panel_pkg::*;
#(
    parameter int NUMBER_OF_DEVICES = 4
)
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    output logic [DEV_IDX_W-1:0] o_count,
    output logic                 o_last
);

    localparam logic [DEV_IDX_W-1:0] LAST_IDX = DEV_IDX_W'(NUMBER_OF_DEVICES - 1);

    logic [DEV_IDX_W-1:0] r_count;

    // Advance once per enable, wrapping at the last device of the chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (i_en)
            r_count <= (r_count == LAST_IDX) ? '0 : r_count + DEV_IDX_W'(1);
    end

    assign o_count = r_count;
    assign o_last  = (r_count == LAST_IDX);

endmodule

// File: rtl/led_panel_scan_ctrl.sv
// LED panel scan controller: pulls one word per daisy-chained driver device,
// shifts it out MSB first on sdi/sclk, pulses le after each device and
// reports frame_done once the whole chain has been loaded.
// Build option: LED_BLANK_ON_LATCH_EN forces oe_n high during every latch cycle.
module led_panel_scan_ctrl
    import led_panel_pkg::*;
#(
    parameter int NUMBER_OF_DEVICES = 4,
    parameter int BITS_PER_DEVICE   = DEFAULT_BITS_PER_DEVICE
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       data_valid,
    input  logic [BITS_PER_DEVICE-1:0] data,
    output logic                       data_ready,
    output logic                       sdi,
    output logic                       sclk,
    output logic                       le,
    output logic                       oe_n,
    output logic [DEV_IDX_W-1:0]       dev_idx,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int BC_W = (BITS_PER_DEVICE > 1) ? $clog2(BITS_PER_DEVICE) : 1;

    state_t                     r_state;
    logic [BITS_PER_DEVICE-1:0] r_shreg;
    logic [BC_W-1:0]            r_bit_cnt;
    logic                       r_phase;     // 0: sclk low phase, 1: sclk high phase
    logic                       r_sdi;
    logic                       r_sclk;
    logic                       r_le;
    logic                       r_data_ready;
    logic                       r_busy;
    logic                       r_frame_done;
    logic                       r_oe_n;
    logic                       r_lit;       // a full frame has been latched since reset

    logic [BITS_PER_DEVICE-1:0] w_shreg_next;
    logic                       w_last_bit;
    logic                       w_last_dev;
    logic                       w_cnt_en;

    assign w_shreg_next = r_shreg << 1;
    assign w_last_bit   = (r_bit_cnt == BC_W'(BITS_PER_DEVICE - 1));
    assign w_cnt_en     = (r_state == ST_LATCH);

    led_dev_counter #(
        .NUMBER_OF_DEVICES (NUMBER_OF_DEVICES)
    ) u_dev_counter (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (w_cnt_en),
        .o_count (dev_idx),
        .o_last  (w_last_dev)
    );

    // Frame sequencer; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_phase      <= 1'b0;
            r_sdi        <= 1'b0;
            r_sclk       <= 1'b0;
            r_le         <= 1'b0;
            r_data_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_oe_n       <= 1'b1;
            r_lit        <= 1'b0;
        end else begin
            r_le         <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_WAIT_DATA;
                        r_data_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ST_WAIT_DATA: begin
                    if (data_valid && r_data_ready) begin
                        r_state      <= ST_SHIFT;
                        r_shreg      <= data;
                        r_bit_cnt    <= '0;
                        r_phase      <= 1'b0;
                        r_data_ready <= 1'b0;
                        r_sdi        <= data[BITS_PER_DEVICE-1];
                        r_sclk       <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                        r_sclk  <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_shreg <= w_shreg_next;
                        if (w_last_bit) begin
                            r_state <= ST_LATCH;
                            r_sdi   <= 1'b0;
                            r_le    <= 1'b1;
`ifdef LED_BLANK_ON_LATCH_EN
                            r_oe_n  <= 1'b1;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BC_W'(1);
                            r_sdi     <= w_shreg_next[BITS_PER_DEVICE-1];
                        end
                    end
                end
                ST_LATCH: begin
                    // Leave any latch blanking; stays dark until the first frame completes.
                    r_oe_n <= ~r_lit;
                    if (w_last_dev) begin
                        r_state      <= ST_DONE;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_state      <= ST_WAIT_DATA;
                        r_data_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_lit   <= 1'b1;
                    r_oe_n  <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_sdi        <= 1'b0;
                    r_sclk       <= 1'b0;
                    r_data_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign sdi        = r_sdi;
    assign sclk       = r_sclk;
    assign le         = r_le;
    assign data_ready = r_data_ready;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign oe_n       = r_oe_n;

endmodule

// File: tb/tb_led_panel_scan_ctrl.sv
// Directed bench for led_panel_scan_ctrl: table of frame scenarios on a
// 4x16 chain plus hand sequences for mid-frame reset and a 1-device chain.
// Cycle numbering: cyc counts rising edges, the edge that samples start is cyc 1.
module tb_led_panel_scan_ctrl;

    localparam int N     = 4;
    localparam int B     = 16;
    localparam int DEV_T = 2*B + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, data_valid = 1'b0;
    logic [15:0] data = '0;
    logic        data_ready, sdi, sclk, le, oe_n, busy, frame_done;
    logic [4:0]  dev_idx;

    logic        start1 = 1'b0, dv1 = 1'b0;
    logic [3:0]  data1 = '0;
    logic        data_ready1, sdi1, sclk1, le1, oe_n1, busy1, frame_done1;
    logic [4:0]  dev_idx1;

    led_panel_scan_ctrl #(.NUMBER_OF_DEVICES(N), .BITS_PER_DEVICE(B)) dut (
        .clk(clk), .rst(rst), .start(start), .data_valid(data_valid), .data(data),
        .data_ready(data_ready), .sdi(sdi), .sclk(sclk), .le(le), .oe_n(oe_n),
        .dev_idx(dev_idx), .busy(busy), .frame_done(frame_done));

    led_panel_scan_ctrl #(.NUMBER_OF_DEVICES(1), .BITS_PER_DEVICE(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_valid(dv1), .data(data1),
        .data_ready(data_ready1), .sdi(sdi1), .sclk(sclk1), .le(le1), .oe_n(oe_n1),
        .dev_idx(dev_idx1), .busy(busy1), .frame_done(frame_done1));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int tb_lit  = 0;

    typedef struct {
        logic [15:0] data;
        int          stall_dev;
        int          stall_len;
        int          start_at;
        bit          start_in_done;
        int          exp_done;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame from IDLE and checks timing, serial data and side outputs.
    task automatic run_frame(input vec_t v);
        int          cyc = 0, le_k = 0, done_cyc = -1, done_cnt = 0;
        int          bad_hs = 0, bad_oe = 0, bad_stall = 0, nbits = 0;
        int          stall_left, exp_le;
        logic        exp_oe;
        logic        stalled_prev = 1'b0, prev_sclk = 1'b0, prev_sdi = 1'b0;
        logic [15:0] word = '0;
        stall_left = v.stall_len;
        start = 1'b1; data = v.data; data_valid = 1'b1;
        while (cyc < 400 && !(done_cyc >= 0 && cyc >= done_cyc + 5)) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) begin
                check("busy_after_start", busy, 1);
                check("ready_after_start", data_ready, 1);
            end
            exp_oe = (tb_lit != 0) ? 1'b0 : 1'b1;
`ifdef LED_BLANK_ON_LATCH_EN
            if (le) exp_oe = 1'b1;
`endif
            if (oe_n !== exp_oe) bad_oe++;
            if (data_ready && (!busy || sclk || le || sdi)) bad_hs++;
            if (!busy && (data_ready || sclk || le || sdi || dev_idx != 0)) bad_hs++;
            if ((le || frame_done) && sdi) bad_hs++;
            if (frame_done && (le || !busy)) bad_hs++;
            if (done_cyc >= 0 && cyc > done_cyc && (busy || frame_done)) bad_hs++;
            if (stalled_prev && !(data_ready && !sclk && !le)) bad_stall++;
            if (sclk && !prev_sclk) begin
                word = {word[14:0], sdi};
                nbits++;
                if (sdi !== prev_sdi) bad_hs++;
            end
            if (le) begin
                exp_le = DEV_T*(le_k + 1) + ((v.stall_len > 0 && le_k >= v.stall_dev) ? v.stall_len : 0);
                check($sformatf("le%0d_cycle", le_k), cyc, exp_le);
                check($sformatf("le%0d_dev_idx", le_k), dev_idx, le_k);
                check($sformatf("le%0d_sdi_word", le_k), word, v.data);
                check($sformatf("le%0d_sdi_bits", le_k), nbits, B);
                word = '0; nbits = 0; le_k++;
            end
            if (frame_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                tb_lit = 1;
            end
            prev_sclk = sclk;
            prev_sdi  = sdi;
            // next-cycle stimulus
            start = (cyc == v.start_at);
            if (v.start_in_done && frame_done) start = 1'b1;
            if (data_ready && dev_idx == v.stall_dev && stall_left > 0) begin
                data_valid = 1'b0;
                stall_left--;
            end else begin
                data_valid = 1'b1;
            end
            stalled_prev = !data_valid;
        end
        check("done_cycle", done_cyc, v.exp_done);
        check("done_count", done_cnt, 1);
        check("le_count", le_k, N);
        check("oe_n_bad_cycles", bad_oe, 0);
        check("protocol_bad_cycles", bad_hs, 0);
        check("stall_bad_cycles", bad_stall, 0);
        start = 1'b0; data_valid = 1'b0;
    endtask

    initial begin
        int          cyc, le_c, dn, bad;
        logic        ps;
        logic [3:0]  w1;

        //            data      stall_dev stall_len start_at in_done exp_done
        vecs[0] = '{16'hA5C3, -1,  0,  0, 1'b0, 137};
        vecs[1] = '{16'hA5C3,  2, 10,  0, 1'b0, 147};
        vecs[2] = '{16'h3C96, -1,  0, 40, 1'b0, 137};
        vecs[3] = '{16'h8001, -1,  0,  0, 1'b1, 137};

        #1 rst = 1'b0;
        #2;
        check("rst_sdi", sdi, 0);
        check("rst_sclk", sclk, 0);
        check("rst_le", le, 0);
        check("rst_data_ready", data_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_oe_n", oe_n, 1);
        check("rst_dev_idx", dev_idx, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Reset in the middle of device 2's shift: frame abandoned, no le.
        start = 1'b1; data = 16'h5A5A; data_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        check("pre_reset_dev_idx", dev_idx, 2);
        #2 rst = 1'b0;
        #1;
        check("midrst_sdi", sdi, 0);
        check("midrst_sclk", sclk, 0);
        check("midrst_le", le, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data_ready", data_ready, 0);
        check("midrst_oe_n", oe_n, 1);
        check("midrst_dev_idx", dev_idx, 0);
        tb_lit = 0;
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (le || busy || frame_done) bad++;
        end
        check("midrst_quiet", bad, 0);
        #2 rst = 1'b1;
        data_valid = 1'b0;
        @(posedge clk); #1;
        run_frame(vecs[0]);

        // Single-device chain, 4-bit words.
        start1 = 1'b1; dv1 = 1'b1; data1 = 4'b1001;
        cyc = 0; le_c = -1; dn = -1; bad = 0; ps = 1'b0; w1 = '0;
        while (cyc < 50 && dn < 0) begin
            @(posedge clk); #1; cyc++;
            start1 = 1'b0;
            if (dev_idx1 != 0) bad++;
            if (sclk1 && !ps) w1 = {w1[2:0], sdi1};
            ps = sclk1;
            if (le1 && le_c < 0) le_c = cyc;
            if (frame_done1) dn = cyc;
        end
        check("n1_le_cycle", le_c, 10);
        check("n1_done_cycle", dn, 11);
        check("n1_done_after_le", dn - le_c, 1);
        check("n1_sdi_word", w1, 4'b1001);
        @(posedge clk); #1;
        if (dev_idx1 != 0) bad++;
        check("n1_dev_idx_bad", bad, 0);
        check("n1_idle_busy", busy1, 0);
        dv1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
